// File: rtl/axi_rd_pkg.sv
// Shared constants for the AXI read arbiter: default IDs, AR FSM states,
// fixed AXI burst attributes and grant encodings.
package axi_rd_pkg;

   localparam logic [3:0] INST_ID_DEF = 4'd0;
   localparam logic [3:0] DATA_ID_DEF = 4'd1;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam logic [7:0] LEN_SINGLE  = 8'd0;

   // Grant vector layout: bit 0 = instruction, bit 1 = data
   localparam logic [1:0] GNT_NONE    = 2'b00;
   localparam logic [1:0] GNT_INST    = 2'b01;
   localparam logic [1:0] GNT_DATA    = 2'b10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_AR   = 1'b1
   } ar_state_e;

   function automatic logic [2:0] ar_size_sel(input logic       i_is_data,
                                              input logic [2:0] i_data_size);
      return i_is_data ? i_data_size : SIZE_WORD;
   endfunction

endpackage

// File: rtl/axi_rd_grant.sv
// Two-way grant selector for the AXI read arbiter. With ARB_RR_EN defined,
// contention alternates via last_grant; otherwise data always wins.
module axi_rd_grant
   import axi_rd_pkg::*;
(
`ifdef ARB_RR_EN
   input  logic       clk,
   input  logic       rst,
   input  logic       i_take,
`endif
   input  logic       i_inst_elig,
   input  logic       i_data_elig,
   output logic [1:0] o_grant
);

   logic w_both;

   assign w_both = i_inst_elig & i_data_elig;

`ifdef ARB_RR_EN
   // r_last_grant = 1 means data won the most recent contention
   logic r_last_grant;

   // Winner selection: alternate on contention, otherwise the sole eligible requester
   always_comb begin
      o_grant = GNT_NONE;
      if (w_both) begin
         o_grant = r_last_grant ? GNT_INST : GNT_DATA;
      end else begin
         o_grant = {i_data_elig, i_inst_elig};
      end
   end

   // Only contended grants move the round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= 1'b0;
      end else if (i_take && w_both) begin
         r_last_grant <= ~r_last_grant;
      end else begin
         r_last_grant <= r_last_grant;
      end
   end
`else
   // Fixed priority: loads beat instruction fetches
   always_comb begin
      o_grant = GNT_NONE;
      if (w_both) begin
         o_grant = GNT_DATA;
      end else begin
         o_grant = {i_data_elig, i_inst_elig};
      end
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between the fetch and memory stages, one
// outstanding read per requester. Define ARB_RR_EN for round-robin contention.
module axi_rd_arbiter
   import axi_rd_pkg::*;
#(
   parameter logic [3:0]  INST_ID = INST_ID_DEF,
   parameter logic [3:0]  DATA_ID = DATA_ID_DEF,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   input  logic              inst_rready,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,

   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [2:0]        data_size,
   output logic              data_addr_ok,
   input  logic              data_rready,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,

   output logic [3:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,

   input  logic [3:0]        rid,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   ar_state_e         r_state;
   logic              r_inst_pend;
   logic              r_data_pend;
   logic              r_arvalid;
   logic [3:0]        r_arid;
   logic [ADDR_W-1:0] r_araddr;
   logic [2:0]        r_arsize;

   logic              w_inst_elig;
   logic              w_data_elig;
   logic              w_idle;
   logic [1:0]        w_grant;
   logic              w_gnt_inst;
   logic              w_gnt_data;
   logic              w_rid_inst;
   logic              w_rid_data;
   logic              w_orphan;
   logic              w_rready;
   logic              w_inst_hs;
   logic              w_data_hs;
   logic              w_unused_rsp;

   assign w_inst_elig = inst_req & ~r_inst_pend;
   assign w_data_elig = data_req & ~r_data_pend;
   assign w_idle      = (r_state == S_IDLE);

   axi_rd_grant u_grant (
`ifdef ARB_RR_EN
      .clk         (clk),
      .rst         (rst),
      .i_take      (w_idle),
`endif
      .i_inst_elig (w_inst_elig),
      .i_data_elig (w_data_elig),
      .o_grant     (w_grant)
   );

   // Grants only exist in S_IDLE and never while reset is asserted
   assign w_gnt_inst = w_idle & w_grant[0] & ~rst;
   assign w_gnt_data = w_idle & w_grant[1] & ~rst;

   // Beats whose RID matches no pending owner are drained as orphans
   assign w_rid_inst = (rid == INST_ID) & r_inst_pend;
   assign w_rid_data = (rid == DATA_ID) & r_data_pend;
   assign w_orphan   = ~w_rid_inst & ~w_rid_data;
   assign w_rready   = ~rst & ((w_rid_inst & inst_rready) |
                               (w_rid_data & data_rready) |
                               w_orphan);
   assign w_inst_hs  = rvalid & w_rready & w_rid_inst;
   assign w_data_hs  = rvalid & w_rready & w_rid_data;

   assign w_unused_rsp = ^{rresp, rlast};

   // AR channel FSM with registered AXI address outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_arvalid <= 1'b0;
         r_arid    <= 4'd0;
         r_araddr  <= '0;
         r_arsize  <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_inst || w_gnt_data) begin
                  r_arvalid <= 1'b1;
                  r_arid    <= w_gnt_data ? DATA_ID : INST_ID;
                  r_araddr  <= w_gnt_data ? data_addr : inst_addr;
                  r_arsize  <= ar_size_sel(w_gnt_data, data_size);
                  r_state   <= S_AR;
               end else begin
                  r_state   <= S_IDLE;
               end
            end
            S_AR: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_state   <= S_AR;
               end
            end
            default: begin
               r_arvalid <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   // Outstanding-read flags: set on grant, cleared on the owner's R handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst_pend <= 1'b0;
         r_data_pend <= 1'b0;
      end else begin
         if (w_gnt_inst) begin
            r_inst_pend <= 1'b1;
         end else if (w_inst_hs) begin
            r_inst_pend <= 1'b0;
         end else begin
            r_inst_pend <= r_inst_pend;
         end
         if (w_gnt_data) begin
            r_data_pend <= 1'b1;
         end else if (w_data_hs) begin
            r_data_pend <= 1'b0;
         end else begin
            r_data_pend <= r_data_pend;
         end
      end
   end

   assign inst_addr_ok = w_gnt_inst;
   assign data_addr_ok = w_gnt_data;
   assign inst_data_ok = w_inst_hs;
   assign data_data_ok = w_data_hs;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign arid    = r_arid;
   assign araddr  = r_araddr;
   assign arlen   = LEN_SINGLE;
   assign arsize  = r_arsize;
   assign arburst = BURST_INCR;
   assign arvalid = r_arvalid;
   assign rready  = w_rready;

endmodule
